// File: rtl/note_scheduler.sv
// note_scheduler: frame timing, game-state FSM, lives/level tracking and
// LFSR lane selection that feeds spawn pulses to the four tile columns.
module note_scheduler #(
    parameter int unsigned FRAME_DIV        = 833333,
    parameter int unsigned START_INTERVAL   = 60,
    parameter int unsigned MIN_INTERVAL     = 15,
    parameter int unsigned INTERVAL_STEP    = 5,
    parameter int unsigned HITS_PER_LEVEL   = 10,
    parameter int unsigned INIT_LIVES       = 3,
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter logic [7:0]  LFSR_SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_btn,
    input  logic [3:0] col_busy,
    input  logic [3:0] hit,
    input  logic [3:0] miss,
    output logic       frame_tick,
    output logic [3:0] spawn,
    output logic [1:0] game_state,
    output logic       play_en,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic [3:0] fall_speed
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        OVER      = 2'd3
    } state_t;

    localparam int DIV_W = $clog2(FRAME_DIV + 1);
    localparam int CD_W  = $clog2(COUNTDOWN_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [7:0]       HPL      = 8'(HITS_PER_LEVEL);

    state_t           state, state_nx;
    logic [DIV_W-1:0] div_cnt;
    logic [CD_W-1:0]  cd_cnt;
    logic [7:0]       int_cnt;
    logic [7:0]       hit_cnt;
    logic [7:0]       lfsr;
    logic [3:0]       spawn_q;
    logic             start_q;

    logic        start_edge;
    logic        enter_cd;
    logic        spawn_due;
    logic [11:0] step_total;
    logic [7:0]  interval;
    logic [7:0]  int_last;
    logic [2:0]  pop_hit;
    logic [2:0]  pop_miss;
    logic [7:0]  hit_sum;
    logic        level_up;
    logic [2:0]  lives_nx;
    logic [3:0]  pick;
    logic [1:0]  lane;
    logic        found;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

    assign start_edge = start_btn & ~start_q;
    assign enter_cd   = (state == IDLE) && start_edge;

    // Clamp before subtracting so a high level never wraps the interval.
    assign step_total = 12'(level) * 12'(INTERVAL_STEP);
    assign interval   = (step_total + 12'(MIN_INTERVAL) >= 12'(START_INTERVAL))
                      ? 8'(MIN_INTERVAL)
                      : 8'(12'(START_INTERVAL) - step_total);
    assign int_last   = interval - 8'd1;
    assign spawn_due  = (state == PLAY) && frame_tick && (int_cnt == int_last);

    assign pop_hit  = pop4(hit);
    assign pop_miss = pop4(miss);
    assign hit_sum  = hit_cnt + {5'b0, pop_hit};
    assign level_up = (hit_sum >= HPL);
    assign lives_nx = (pop_miss >= lives) ? 3'd0 : lives - pop_miss;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        lane  = lfsr[1:0];
        for (int k = 0; k < 4; k++) begin
            lane = lfsr[1:0] + 2'(k);
            if (!found && !col_busy[lane]) begin
                pick[lane] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start_edge) state_nx = COUNTDOWN;
            COUNTDOWN: if (frame_tick && cd_cnt == CD_LAST) state_nx = PLAY;
            PLAY:      if (lives == 3'd0) state_nx = OVER;
            OVER:      if (start_edge) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
            cd_cnt     <= '0;
            int_cnt    <= '0;
            hit_cnt    <= '0;
            lfsr       <= LFSR_SEED;
            spawn_q    <= '0;
            start_q    <= 1'b0;
            lives      <= 3'(INIT_LIVES);
            level      <= '0;
        end else begin
            start_q    <= start_btn;
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            frame_tick <= (div_cnt == DIV_LAST);
            div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            spawn_q    <= spawn_due ? pick : 4'b0;

            if (state == COUNTDOWN && frame_tick) cd_cnt <= cd_cnt + 1'b1;

            if (enter_cd) begin
                lives   <= 3'(INIT_LIVES);
                level   <= '0;
                hit_cnt <= '0;
                int_cnt <= '0;
                cd_cnt  <= '0;
            end

            if (state == PLAY) begin
                lives   <= lives_nx;
                hit_cnt <= level_up ? hit_sum - HPL : hit_sum;
                if (level_up && level != 4'd15) level <= level + 1'b1;
                if (frame_tick) int_cnt <= spawn_due ? 8'd0 : int_cnt + 8'd1;
            end
        end
    end

    assign game_state = state;
    assign play_en    = (state == PLAY);
    assign spawn      = play_en ? spawn_q : 4'b0;
    assign fall_speed = 4'd1 + {1'b0, level[3:1]};
endmodule

// File: tb/tb_note_scheduler.sv
// Testbench for note_scheduler: random and directed stimulus against a
// frame/game-level reference model, with small test parameters.
module tb_note_scheduler;
    localparam int FD   = 4;
    localparam int CF   = 3;
    localparam int SI   = 4;
    localparam int MI   = 2;
    localparam int STEP = 1;
    localparam int HPL  = 2;
    localparam int INIT = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_btn;
    logic [3:0] col_busy, hit, miss;
    logic       frame_tick;
    logic [3:0] spawn;
    logic [1:0] game_state;
    logic       play_en;
    logic [2:0] lives;
    logic [3:0] level;
    logic [3:0] fall_speed;

    note_scheduler #(
        .FRAME_DIV(FD), .START_INTERVAL(SI), .MIN_INTERVAL(MI),
        .INTERVAL_STEP(STEP), .HITS_PER_LEVEL(HPL), .INIT_LIVES(INIT),
        .COUNTDOWN_FRAMES(CF), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_btn(start_btn),
        .col_busy(col_busy), .hit(hit), .miss(miss),
        .frame_tick(frame_tick), .spawn(spawn), .game_state(game_state),
        .play_en(play_en), .lives(lives), .level(level),
        .fall_speed(fall_speed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: game-level quantities as plain integers.
    int m_div, m_tick, m_state, m_frames_cd, m_frames_play;
    int m_lives, m_level, m_hits, m_lfsr, m_spawn, m_start_q;

    function automatic int spawn_interval(input int lvl);
        int iv;
        iv = SI - lvl * STEP;
        return (iv < MI) ? MI : iv;
    endfunction

    task automatic model_reset();
        m_div = 0; m_tick = 0; m_state = 0; m_frames_cd = 0;
        m_frames_play = 0; m_lives = INIT; m_level = 0; m_hits = 0;
        m_lfsr = 8'hA5; m_spawn = 0; m_start_q = 0;
    endtask

    task automatic model_step();
        int n_state, n_cd, n_fp, n_lives, n_level, n_hits, n_spawn;
        int lane, l, fb;
        bit edge_s;
        if (!reset_n) begin
            model_reset();
            return;
        end
        edge_s = start_btn && !m_start_q;
        n_state = m_state; n_cd = m_frames_cd; n_fp = m_frames_play;
        n_lives = m_lives; n_level = m_level; n_hits = m_hits; n_spawn = 0;
        lane = -1;
        for (int k = 0; k < 4; k++) begin
            l = (m_lfsr % 4 + k) % 4;
            if (lane < 0 && !col_busy[l]) lane = l;
        end
        case (m_state)
            0: if (edge_s) begin
                n_state = 1; n_lives = INIT; n_level = 0;
                n_hits = 0; n_fp = 0; n_cd = 0;
            end
            1: if (m_tick != 0) begin
                n_cd = m_frames_cd + 1;
                if (n_cd == CF) n_state = 2;
            end
            2: begin
                if (m_lives == 0) n_state = 3;
                if (m_tick != 0) begin
                    n_fp = m_frames_play + 1;
                    if (n_fp == spawn_interval(m_level)) begin
                        n_fp = 0;
                        if (lane >= 0) n_spawn = 1 << lane;
                    end
                end
                n_lives = m_lives - $countones(miss);
                if (n_lives < 0) n_lives = 0;
                n_hits = (m_hits + $countones(hit)) % 256;
                if (n_hits >= HPL) begin
                    n_hits -= HPL;
                    if (m_level < 15) n_level = m_level + 1;
                end
            end
            default: if (edge_s) n_state = 0;
        endcase
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
        m_tick = (m_div == FD - 1) ? 1 : 0;
        m_div = (m_div + 1) % FD;
        m_state = n_state; m_frames_cd = n_cd; m_frames_play = n_fp;
        m_lives = n_lives; m_level = n_level; m_hits = n_hits;
        m_spawn = n_spawn; m_start_q = int'(start_btn);
    endtask

    task automatic compare_all();
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
        check("spawn", 32'(spawn), 32'((m_state == 2) ? m_spawn : 0));
        check("game_state", 32'(game_state), 32'(m_state));
        check("play_en", 32'(play_en), 32'(m_state == 2));
        check("lives", 32'(lives), 32'(m_lives));
        check("level", 32'(level), 32'(m_level));
        check("fall_speed", 32'(fall_speed), 32'(1 + m_level / 2));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tick"}, 32'(frame_tick), 32'(0));
        check({tag, "_spawn"}, 32'(spawn), 32'(0));
        check({tag, "_state"}, 32'(game_state), 32'(0));
        check({tag, "_play_en"}, 32'(play_en), 32'(0));
        check({tag, "_lives"}, 32'(lives), 32'(INIT));
        check({tag, "_level"}, 32'(level), 32'(0));
        check({tag, "_speed"}, 32'(fall_speed), 32'(1));
        check({tag, "_lfsr"}, 32'(dut.lfsr), 32'(8'hA5));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_inputs(input int hit_pct, input int miss_pct);
        col_busy = 4'($urandom);
        hit  = ($urandom_range(0, 99) < hit_pct) ? 4'($urandom) : 4'b0;
        miss = ($urandom_range(0, 99) < miss_pct) ? 4'($urandom) : 4'b0;
    endtask

    task automatic wait_play(input string tag);
        int n;
        n = 0;
        while (m_state != 2 && n < 200) begin
            cycle();
            n++;
        end
        check(tag, 32'(game_state), 32'(2));
    endtask

    initial begin
        int ticks, seen;
        bit pending;
        reset_n = 1'b0; start_btn = 1'b0;
        col_busy = '0; hit = '0; miss = '0;
        model_reset();
        #12;
        check_reset_values("por");
        @(negedge clk);
        reset_n = 1'b1;

        ticks = 0;
        repeat (40) begin
            cycle();
            if (frame_tick) ticks++;
        end
        check("idle_ticks", 32'(ticks), 32'(10));

        start_btn = 1'b1;
        cycle();
        check("start_cd", 32'(game_state), 32'(1));
        repeat (5) cycle();
        start_btn = 1'b0;
        wait_play("to_play");

        ticks = 0;
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            cycle();
            if (frame_tick) ticks++;
            if (spawn != 0) seen = 1;
        end
        check("first_spawn_ticks", 32'(ticks), 32'(4));
        check("first_spawn_onehot", 32'($onehot(spawn)), 32'(1));

        repeat (100) begin
            rand_inputs(0, 0);
            cycle();
        end

        col_busy = 4'b1111;
        seen = 0;
        repeat (5 * SI * FD) begin
            cycle();
            if (spawn != 0) seen++;
        end
        check("all_busy_spawns", 32'(seen), 32'(0));

        col_busy = 4'b1110;
        seen = 0;
        repeat (16 * FD) begin
            cycle();
            if (spawn != 0) begin
                seen++;
                check("wrap_lane", 32'(spawn), 32'(4'b0001));
            end
        end
        check("wrap_seen", 32'(seen > 0), 32'(1));

        for (int i = 0; i < 20; i++) begin
            rand_inputs(0, 0);
            hit = 4'b0011;
            cycle();
            if (i == 0) begin
                check("lvl1", 32'(level), 32'(1));
                check("lvl1_speed", 32'(fall_speed), 32'(1));
            end
            hit = 4'b0000;
            cycle();
        end
        check("lvl_sat", 32'(level), 32'(15));
        check("lvl_sat_speed", 32'(fall_speed), 32'(8));

        repeat (150) begin
            rand_inputs(10, 0);
            cycle();
        end
        hit = '0;

        check("pre_miss_lives", 32'(lives), 32'(3));
        miss = 4'b0111;
        cycle();
        miss = 4'b0;
        check("miss_lives", 32'(lives), 32'(0));
        cycle();
        check("over_state", 32'(game_state), 32'(3));
        repeat (8) begin
            col_busy = 4'b0;
            cycle();
            check("over_spawn", 32'(spawn), 32'(0));
        end

        start_btn = 1'b1;
        repeat (4) cycle();
        check("held_start_idle", 32'(game_state), 32'(0));
        start_btn = 1'b0;
        cycle();
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        check("restart_state", 32'(game_state), 32'(1));
        check("restart_lives", 32'(lives), 32'(3));
        check("restart_level", 32'(level), 32'(0));
        wait_play("to_play2");

        pending = 1'b0;
        for (int i = 0; i < 200 && !pending; i++) begin
            rand_inputs(0, 0);
            col_busy = 4'b0;
            cycle();
            pending = (m_state == 2 && m_tick != 0 &&
                       m_frames_play + 1 == spawn_interval(m_level));
        end
        check("spawn_pending", 32'(pending), 32'(1));
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async");
        cycle();
        reset_n = 1'b1;
        cycle();
        check("post_release_spawn", 32'(spawn), 32'(0));

        repeat (600) begin
            rand_inputs(10, 3);
            start_btn = ($urandom_range(0, 99) < 4);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
